// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Groups the control and status signals of countdown_timer.
//   master: the controller side (drives load/start/pause, reads status).
//   slave : the timer itself.
//   Signals:
//     ld_def    - load def_value and return to IDLE
//     def_value - preset {min_tens, min_ones, sec_tens, sec_ones}, BCD
//     start     - level-sampled start/resume request
//     pause     - level-sampled pause request
//     value     - current count, same packing as def_value
//     running   - high in RUN
//     paused    - high in PAUSE
//     expired   - high in EXPIRED
//     done      - one-cycle pulse on reaching 00:00
interface countdown_timer_if;
    logic        ld_def;
    logic [15:0] def_value;
    logic        start;
    logic        pause;
    logic [15:0] value;
    logic        running;
    logic        paused;
    logic        expired;
    logic        done;

    modport master (
        output ld_def, def_value, start, pause,
        input  value, running, paused, expired, done
    );

    modport slave (
        input  ld_def, def_value, start, pause,
        output value, running, paused, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Four-digit BCD countdown timer (MM:SS, 00:00-99:59). Loaded from a
//   saturated preset, started/paused by level-sampled requests, and
//   decremented once every TICK_DIV run cycles through a BCD borrow chain.
//   Reaching 00:00 enters EXPIRED and pulses done for one cycle.
//   Parameters:
//     TICK_DIV - clock cycles per countdown tick (>= 1)
//   Ports:
//     clk   - clock, rising edge
//     rst_n - synchronous active-low reset
//     bus   - countdown_timer_if.slave (control inputs, status outputs)
//   All outputs come straight from registers.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   value_q, value_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q,  done_d;

    // Clamp each digit of a preset to its legal BCD range.
    function automatic logic [15:0] sat_bcd(input logic [15:0] d);
        logic [15:0] r;
        r[15:12] = (d[15:12] > 4'd9) ? 4'd9 : d[15:12];
        r[11:8]  = (d[11:8]  > 4'd9) ? 4'd9 : d[11:8];
        r[7:4]   = (d[7:4]   > 4'd5) ? 4'd5 : d[7:4];
        r[3:0]   = (d[3:0]   > 4'd9) ? 4'd9 : d[3:0];
        return r;
    endfunction

    // One-second decrement with borrow rippling sec_ones -> min_tens.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = (v[3:0] == 4'd0);
        r[3:0] = b ? 4'd9 : v[3:0] - 4'd1;
        if (b) begin
            b = (v[7:4] == 4'd0);
            r[7:4] = b ? 4'd5 : v[7:4] - 4'd1;
            if (b) begin
                b = (v[11:8] == 4'd0);
                r[11:8] = b ? 4'd9 : v[11:8] - 4'd1;
                if (b) begin
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            value_q <= sat_bcd(bus.def_value);
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (bus.ld_def) begin
            state_d = S_IDLE;
            value_d = sat_bcd(bus.def_value);
            presc_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.pause && (value_q != 16'h0000)) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (state_q == S_RUN && bus.pause) begin
                        state_d = S_PAUSE;
                    end else if (state_q == S_RUN || (bus.start && !bus.pause)) begin
                        // The resume edge out of PAUSE advances the prescaler
                        // like any RUN edge, so the retained partial tick
                        // completes after the same total of counted edges.
                        state_d = S_RUN;
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            value_d = dec_bcd(value_q);
                            if (dec_bcd(value_q) == 16'h0000) begin
                                state_d = S_EXPIRED;
                                done_d  = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
                S_EXPIRED: begin
                    state_d = S_EXPIRED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        bus.value   = value_q;
        bus.running = (state_q == S_RUN);
        bus.paused  = (state_q == S_PAUSE);
        bus.expired = (state_q == S_EXPIRED);
        bus.done    = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_def = 1'b0;
    logic [15:0] def_value = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    countdown_timer_if if0 ();
    countdown_timer_if if1 ();
    countdown_timer_if if2 ();

    assign if0.ld_def = ld_def;  assign if0.def_value = def_value;
    assign if0.start  = start;   assign if0.pause     = pause;
    assign if1.ld_def = ld_def;  assign if1.def_value = def_value;
    assign if1.start  = start;   assign if1.pause     = pause;
    assign if2.ld_def = ld_def;  assign if2.def_value = def_value;
    assign if2.start  = start;   assign if2.pause     = pause;

    countdown_timer #(.TICK_DIV(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    countdown_timer #(.TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    countdown_timer #(.TICK_DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Reference model: remaining time kept as plain seconds.
    int divs [3] = '{4, 1, 2};
    int m_secs [3];
    int m_cnt  [3];
    bit m_run  [3];
    bit m_pse  [3];
    bit m_exp  [3];
    bit m_dn   [3];

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int preset_secs(logic [15:0] d);
        int mt, mo, st, so;
        mt = min_i(int'(d[15:12]), 9);
        mo = min_i(int'(d[11:8]), 9);
        st = min_i(int'(d[7:4]), 5);
        so = min_i(int'(d[3:0]), 9);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] secs_to_bcd(int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic model_advance(int k);
        m_cnt[k]++;
        if (m_cnt[k] == divs[k]) begin
            m_cnt[k] = 0;
            m_secs[k]--;
            if (m_secs[k] == 0) begin
                m_run[k] = 0;
                m_exp[k] = 1;
                m_dn[k]  = 1;
            end
        end
    endtask

    task automatic model_step(int k);
        m_dn[k] = 0;
        if (!rst_n || ld_def) begin
            m_secs[k] = preset_secs(def_value);
            m_cnt[k] = 0;
            m_run[k] = 0; m_pse[k] = 0; m_exp[k] = 0;
        end else if (m_run[k]) begin
            if (pause) begin
                m_run[k] = 0;
                m_pse[k] = 1;
            end else begin
                model_advance(k);
            end
        end else if (m_pse[k]) begin
            if (start && !pause) begin
                m_pse[k] = 0;
                m_run[k] = 1;
                model_advance(k);
            end
        end else if (!m_exp[k]) begin
            if (start && !pause && m_secs[k] != 0) begin
                m_run[k] = 1;
                m_cnt[k] = 0;
            end
        end
    endtask

    function automatic logic [19:0] model_out(int k);
        return {secs_to_bcd(m_secs[k]), m_run[k], m_pse[k], m_exp[k], m_dn[k]};
    endfunction

    function automatic logic [19:0] dut_out(int k);
        case (k)
            0: return {if0.value, if0.running, if0.paused, if0.expired, if0.done};
            1: return {if1.value, if1.running, if1.paused, if1.expired, if1.done};
            default: return {if2.value, if2.running, if2.paused, if2.expired, if2.done};
        endcase
    endfunction

    task automatic compare(string name, int k, logic [19:0] got, logic [19:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got value=%h flags=%b want value=%h flags=%b",
                     name, k, got[19:4], got[3:0], want[19:4], want[3:0]);
        end
    endtask

    task automatic apply(bit r, bit l, logic [15:0] d, bit s, bit p);
        rst_n = r; ld_def = l; def_value = d; start = s; pause = p;
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) compare("model", k, dut_out(k), model_out(k));
    endtask

    typedef struct {
        bit          r;
        bit          l;
        logic [15:0] d;
        bit          s;
        bit          p;
        int          k;
        bit          chk;
        logic [15:0] ev;
        logic [3:0]  ef;
    } vec_t;

    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_RUN  = 4'b1000;
    localparam logic [3:0] F_PSE  = 4'b0100;
    localparam logic [3:0] F_EXP  = 4'b0010;
    localparam logic [3:0] F_EXPD = 4'b0011;

    vec_t vq[$];

    function automatic vec_t v(bit r, bit l, logic [15:0] d, bit s, bit p,
                               int k, logic [15:0] ev, logic [3:0] ef);
        vec_t t;
        t.r = r; t.l = l; t.d = d; t.s = s; t.p = p;
        t.k = k; t.chk = 1'b1; t.ev = ev; t.ef = ef;
        return t;
    endfunction

    initial begin
        // Reset and saturation
        vq.push_back(v(0, 0, 16'h0102, 0, 0, 0, 16'h0102, F_IDLE));
        vq.push_back(v(0, 0, 16'h0102, 0, 0, 0, 16'h0102, F_IDLE));
        vq.push_back(v(0, 0, 16'hAB7F, 0, 0, 0, 16'h9959, F_IDLE));
        vq.push_back(v(1, 1, 16'hF0F0, 0, 0, 0, 16'h9050, F_IDLE));
        // Basic countdown, TICK_DIV=4
        vq.push_back(v(1, 1, 16'h0100, 0, 0, 0, 16'h0100, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 0, 16'h0100, F_RUN));
        for (int i = 0; i < 3; i++) vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0100, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0059, F_RUN));
        for (int i = 0; i < 3; i++) vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0059, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0058, F_RUN));
        // Full borrow chain, TICK_DIV=1
        vq.push_back(v(1, 1, 16'h1000, 0, 0, 1, 16'h1000, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 1, 16'h1000, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 1, 16'h0959, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 1, 16'h0958, F_RUN));
        // Expiry, TICK_DIV=2
        vq.push_back(v(1, 1, 16'h0002, 0, 0, 2, 16'h0002, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 2, 16'h0002, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 2, 16'h0002, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 2, 16'h0001, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 2, 16'h0001, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 2, 16'h0000, F_EXPD));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 2, 16'h0000, F_EXP));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 2, 16'h0000, F_EXP));
        vq.push_back(v(1, 0, 16'h0000, 0, 1, 2, 16'h0000, F_EXP));
        // Pause/resume, TICK_DIV=4
        vq.push_back(v(1, 1, 16'h0010, 0, 0, 0, 16'h0010, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 0, 16'h0010, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0010, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 1, 0, 16'h0010, F_PSE));
        for (int i = 0; i < 4; i++) vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0010, F_PSE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 0, 16'h0010, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0010, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0009, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 1, 1, 0, 16'h0009, F_PSE));
        vq.push_back(v(1, 0, 16'h0000, 1, 1, 0, 16'h0009, F_PSE));
        // Load/start corner cases
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 0, 16'h0009, F_RUN));
        vq.push_back(v(1, 1, 16'h0230, 1, 0, 0, 16'h0230, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0230, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 0, 16'h0230, F_RUN));
        for (int i = 0; i < 3; i++) vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0230, F_RUN));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0229, F_RUN));
        vq.push_back(v(1, 1, 16'h0000, 0, 0, 0, 16'h0000, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 1, 0, 0, 16'h0000, F_IDLE));
        vq.push_back(v(1, 1, 16'h0500, 1, 0, 0, 16'h0500, F_IDLE));
        vq.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0500, F_IDLE));

        #2;
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].r, vq[i].l, vq[i].d, vq[i].s, vq[i].p);
            if (vq[i].chk)
                compare($sformatf("vec%0d", i), vq[i].k, dut_out(vq[i].k), {vq[i].ev, vq[i].ef});
        end

        // Randomized traffic against the model; small presets make expiry common.
        for (int i = 0; i < 4000; i++) begin
            bit          r, l, s, p;
            logic [15:0] d;
            r = ($urandom_range(0, 299) != 0);
            l = ($urandom_range(0, 29) == 0);
            d = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
            s = ($urandom_range(0, 2) == 0);
            p = ($urandom_range(0, 6) == 0);
            apply(r, l, d, s, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Four-digit BCD countdown timer (MM:SS, 00:00–99:59). It is loaded from a preset, started and paused by control pulses, and decrements once per prescaled tick with a BCD borrow chain across the digits. It flags expiry with a one-cycle `done` pulse. It is the down-counting counterpart to the team's single-digit BCD up-counter and feeds the same seven-segment display path.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per countdown tick; legal range ≥1. Prescaler width is `$clog2(TICK_DIV)`, minimum 1.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `ld_def` input 1: load `def_value` and return to IDLE.
- `def_value` input 16: preset `{min_tens, min_ones, sec_tens, sec_ones}`, 4-bit BCD each.
- `start` input 1: level-sampled start/resume request.
- `pause` input 1: level-sampled pause request.
- `value` output 16: current count, same digit packing as `def_value`.
- `running` output 1: high in RUN.
- `paused` output 1: high in PAUSE.
- `expired` output 1: high in EXPIRED.
- `done` output 1: one-cycle pulse on reaching 00:00.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED. `running`, `paused` and `expired` decode the state directly.
- **Reset** (`rst_n`=0 at an edge):
  - `value` ← saturated `def_value`.
  - State ← IDLE; prescaler ← 0; `done` ← 0.
  - All outputs are therefore defined one edge after reset is asserted.
- **Priority:** `rst_n` > `ld_def` > `pause` > `start`.
- **`ld_def`** in any state:
  - `value` ← saturated `def_value`; prescaler ← 0; state ← IDLE.
  - `start`/`pause` are ignored that cycle.
- **Saturation on load:**
  - `min_tens`, `min_ones`, `sec_ones` > 9 become 9.
  - `sec_tens` > 5 becomes 5.
- **IDLE:**
  - `start`=1, `pause`=0 and `value`≠0000 → RUN, prescaler ← 0.
  - `start` with `value`=0000 is ignored; stay IDLE, no `done`.
- **RUN:**
  - `pause`=1 → PAUSE. `value` and prescaler freeze; no tick occurs that edge.
  - Otherwise the prescaler increments. When it equals `TICK_DIV`-1 it wraps to 0 and a tick decrements `value`.
- **PAUSE:**
  - `start`=1 and `pause`=0 → RUN. The prescaler is retained, so the partial tick resumes.
  - `start` and `pause` both high → stay PAUSE.
- **Decrement (BCD borrow chain):**
  - `sec_ones`: 0→9 with borrow, else −1.
  - `sec_tens`: on borrow-in, 0→5 with borrow, else −1.
  - `min_ones`: on borrow-in, 0→9 with borrow, else −1.
  - `min_tens`: on borrow-in, −1. This never underflows, because RUN is left at 0000.
- **Expiry:** a tick that makes `value`=0000 moves to EXPIRED and sets `done`=1 at the same edge. `done` clears at the next edge.
- **EXPIRED:** `value` holds 0000. `start` and `pause` are ignored; only `ld_def` or reset leaves.
- **`done`:** high only in the first EXPIRED cycle; 0 at all other times.

## Timing
- **Start latency:** `start` sampled at edge E0 (IDLE→RUN). The first decrement is at edge E(`TICK_DIV`). Subsequent decrements follow every `TICK_DIV` RUN edges.
- **`TICK_DIV`=1:** decrements on every RUN edge, starting at E1.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **Pause/resume:** total RUN edges between decrements stays exactly `TICK_DIV`. PAUSE edges are not counted.
- **Load visibility:** `ld_def` at edge E makes the new `value` visible after E. This overrides a tick coinciding at E.
- **Reset mid-run:** takes effect at the sampling edge and discards the partial prescale.

## Test plan
- **Reset:** `def_value`=16'h0102, `rst_n` low 2 cycles → `value`=0102, IDLE, `done`=0. With `def_value`=16'hAB7F held in reset → `value`=16'h9959.
- **Basic countdown:** `TICK_DIV`=4, load 16'h0100, pulse `start` at E0 → `value`=0059 after E4, 0058 after E8. `running`=1 throughout.
- **Full borrow chain:** `TICK_DIV`=1, load 16'h1000, `start` → 0959 after E1, 0958 after E2.
- **Expiry:** `TICK_DIV`=2, load 16'h0002, `start` at E0.
  - `value`=0001 after E2; `value`=0000 with `done`=1 and `expired`=1 after E4.
  - `done`=0 after E5.
  - A later `start` leaves `value`=0000 and `done`=0.
- **Pause/resume:** `TICK_DIV`=4, load 16'h0010, `start` at E0, `pause` at E2.
  - `value`=0010 frozen for 5 cycles; `paused`=1.
  - `start` at E7 → `value`=0009 after E9.
  - `start`+`pause` together in PAUSE → stays PAUSE.
- **Load/start corner cases:**
  - `ld_def` with 16'h0230 during RUN → `value`=0230, IDLE, prescaler 0.
  - `start` on 0000 in IDLE → stays IDLE, `done`=0.
  - `ld_def`+`start` together → IDLE.
